uart_tx_fifo_reader: RTL
========================

Name: uart_tx_fifo_reader

Overview:
- Consumer at the read end of the byte FIFO; drains it and serializes each byte onto an 8N1-style asynchronous serial line.
- Pops one word whenever the FIFO reports non-empty and the transmitter is idle. Shifts the word out LSB first with start and stop framing.
- Generates its own 16x-oversampled baud tick, so the bit time is exactly 16*DVSR clocks.
- Sits between the TX FIFO (rd/empty/r_data side) and the board's UART TX pin.

Parameters:
- DBIT, 8: data bits per frame; equals the FIFO word width.
- SB_TICK, 16: stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- DVSR, 163: clocks per oversample tick (100 MHz / (16*38400)); legal range 2 or more.
- DVSR_W, 8: width of the baud divider counter; must satisfy 2**DVSR_W >= DVSR.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_r_data  in  DBIT  FIFO head word; combinational, valid whenever fifo_empty=0.
- fifo_rd  out  1  FIFO pop strobe; single-cycle.
- tx  out  1  serial line; idle high.
- tx_busy  out  1  high while a frame is in flight (any state except IDLE).
- tx_done_tick  out  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk, rising edge.
- Reset values:
  - state = IDLE; tx = 1; fifo_rd = 0; tx_busy = 0; tx_done_tick = 0.
  - Baud counter, tick counter s, bit counter n and shift register all cleared.
- Baud divider:
  - Counter runs 0..DVSR-1; tick = 1 for the one cycle where count == DVSR-1, then the counter wraps to 0.
  - Counter is synchronously cleared on the IDLE->START transition, so the first start-bit tick lands exactly DVSR cycles after leaving IDLE.
- FSM, state IDLE:
  - tx = 1.
  - If fifo_empty = 0: fifo_rd = 1 combinationally in this cycle, shift_reg <= fifo_r_data, s <= 0, state <= START.
  - fifo_rd is never asserted when fifo_empty = 1 or outside IDLE.
- FSM, state START:
  - tx = 0.
  - On tick: if s == 15 then s <= 0, n <= 0, state <= DATA; else s <= s+1.
- FSM, state DATA:
  - tx = shift_reg[0].
  - On tick with s == 15: s <= 0 and shift_reg <= shift_reg >> 1; if n == DBIT-1 then state <= STOP, else n <= n+1.
  - On tick with s < 15: s <= s+1.
- FSM, state STOP:
  - tx = 1.
  - On tick: if s == SB_TICK-1 then tx_done_tick = 1 (one cycle) and state <= IDLE; else s <= s+1.
- Frame timing:
  - Frame length from the pop cycle to the tx_done_tick cycle is (1+DBIT)*16*DVSR + SB_TICK*DVSR clocks.
  - Back-to-back frames: at least one IDLE cycle separates frames. The next pop occurs on the cycle after tx_done_tick if the FIFO is non-empty.
- Arithmetic: s is 5 bits wide to cover SB_TICK up to 32. n is clog2(DBIT) bits wide. All counters wrap only as stated above.
- Boundary conditions:
  - FIFO becomes empty mid-frame: no effect; the current frame completes.
  - FIFO write while IDLE and empty: pop happens on the first cycle fifo_empty reads 0.
  - Reset mid-frame: tx goes high immediately and the FSM returns to IDLE. The in-flight byte is lost, since it was already popped. No partial frame resumes after reset.
  - No glitches on tx: tx is driven from registered state and shift_reg only.

Decomposition:
- Shared package uart_pkg: FSM state encoding localparams (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11), OVERSAMPLE=16, default DVSR and DBIT.
- One sub-module, baud_gen: mod-DVSR counter with sync clear input and tick output. It is shared later with the receive side.

Test Plan:
All scenarios use DVSR=2 (bit time = 32 clk) and a behavioural FIFO model.
- Reset: hold reset 5 cycles with FIFO non-empty -> tx=1, fifo_rd=0, tx_busy=0 throughout; release -> fifo_rd pulses exactly 1 cycle on the next clock.
- Single byte 0xA5:
  - tx sampled at bit centres is 0, then 1,0,1,0,0,1,0,1, then 1.
  - Each level is held 32 clk; stop bit is 32 clk.
  - tx_done_tick fires 320 clk after the pop cycle.
- Back-to-back 0x00 then 0xFF:
  - Two fifo_rd pulses, 321 clk apart.
  - Line reads 0 (start), eight 0s, 1 (stop), 0 (start), eight 1s, 1 (stop).
  - Exactly one IDLE cycle between the frames.
- Empty FIFO: fifo_empty=1 for 1000 clk -> fifo_rd never asserted, tx constant 1, tx_busy 0.
- Reset mid-frame: assert reset at clk 150 of a 0x3C frame -> tx=1 in the same cycle; after release, no resumed data. The next frame starts only with a new pop.
- SB_TICK=32, byte 0x81: stop bit held 64 clk; tx_done_tick fires 352 clk after the pop.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths:
//   - tx_state_t : transmitter FSM state encoding
//   - OVERSAMPLE : oversample ticks per bit
//   - DEF_DVSR / DEF_DBIT : default divider and data width
//   - S_W        : width of the oversample tick counter (covers SB_TICK <= 32)
//   - frame_clocks() : clocks from pop cycle to end-of-stop pulse
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } tx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DEF_DVSR   = 163;
    localparam int DEF_DBIT   = 8;
    localparam int S_W        = 5;

    function automatic int frame_clocks(input int dbit, input int sb_tick, input int dvsr);
        return (1 + dbit) * OVERSAMPLE * dvsr + sb_tick * dvsr;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// ---------------------------------------------------------------------------
// baud_gen
// Mod-DVSR counter producing a one-cycle oversample tick.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   clr   in  synchronous clear; restarts the count at zero
//   tick  out high for the one cycle where the count equals DVSR-1
// ---------------------------------------------------------------------------
module baud_gen #(
    parameter int DVSR   = 163,
    parameter int DVSR_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [DVSR_W-1:0] CNT_LAST = DVSR_W'(DVSR - 1);
    localparam logic [DVSR_W-1:0] CNT_ZERO = DVSR_W'(0);
    localparam logic [DVSR_W-1:0] CNT_ONE  = DVSR_W'(1);

    logic [DVSR_W-1:0] cnt_q;
    logic [DVSR_W-1:0] cnt_d;

    // Next count: clear wins over wrap, wrap wins over increment.
    always_comb begin
        tick = (cnt_q == CNT_LAST);
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (tick) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Divider count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_reader
// Drains a byte FIFO and serialises each word as start bit, DBIT data bits
// (LSB first) and a stop bit of SB_TICK oversample ticks.
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous active-high reset
//   fifo_empty   in  FIFO empty flag
//   fifo_r_data  in  FIFO head word (valid while fifo_empty = 0)
//   fifo_rd      out single-cycle pop strobe (combinational, IDLE only)
//   tx           out serial line, idle high
//   tx_busy      out high while a frame is in flight
//   tx_done_tick out one-cycle pulse on the last tick of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = 16,
    parameter int DVSR    = DEF_DVSR,
    parameter int DVSR_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0]  S_ZERO      = S_W'(0);
    localparam logic [S_W-1:0]  S_ONE       = S_W'(1);
    localparam logic [S_W-1:0]  S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0]  S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0]  N_ZERO      = N_W'(0);
    localparam logic [N_W-1:0]  N_ONE       = N_W'(1);
    localparam logic [N_W-1:0]  N_LAST      = N_W'(DBIT - 1);
    localparam logic [DBIT-1:0] SHIFT_ZERO  = DBIT'(0);

    tx_state_t       state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            baud_clr;
    logic            tick;

    baud_gen #(
        .DVSR   (DVSR),
        .DVSR_W (DVSR_W)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (baud_clr),
        .tick  (tick)
    );

    // FSM next state, counters, shift register and strobes.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        shift_d      = shift_q;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
        baud_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                // Reset gates the pop so nothing is consumed while held in reset.
                if (!fifo_empty && !reset) begin
                    fifo_rd  = 1'b1;
                    shift_d  = fifo_r_data;
                    s_d      = S_ZERO;
                    baud_clr = 1'b1;
                    state_d  = START;
                end else begin
                    state_d  = IDLE;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = S_ZERO;
                        n_d     = N_ZERO;
                        state_d = DATA;
                    end else begin
                        s_d     = s_q + S_ONE;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = S_ZERO;
                        shift_d = shift_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d     = n_q + N_ONE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        s_d          = s_q + S_ONE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level and busy flag decoded from the next state so the registered
    // copies line up with the state register and never glitch.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= S_ZERO;
            n_q     <= N_ZERO;
            shift_q <= SHIFT_ZERO;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule
